// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter: FSM state codes and the
// active-low enable/disable levels used on the breq_/bgrt_/prmt_ signals.
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_TURN  = 2'd2
  } arb_state_e;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin picker: first asserted request found searching last+1,
// last+2, ... (mod NREQ). Purely combinational.
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             valid_o
);

  logic [IDX_W:0] cand;

  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_i} + (IDX_W + 1)'(k);
      if (cand >= (IDX_W + 1)'(NREQ)) cand = cand - (IDX_W + 1)'(NREQ);
      if (!valid_o && req_i[cand[IDX_W-1:0]]) begin
        winner_o = cand[IDX_W-1:0];
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin owner arbiter for the shared bus with a one-cycle turnaround
// between owners and an advisory preempt once the hold time is exceeded.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  breq_,
  output logic [NREQ-1:0]  bgrt_,
  output logic [NREQ-1:0]  prmt_,
  output logic [IDX_W-1:0] owner,
  output logic             busy,
  output arb_state_e       state_dbg
);

  arb_state_e       state_q, state_d;
  logic [NREQ-1:0]  bgrt_q, bgrt_d, prmt_q, prmt_d;
  logic [IDX_W-1:0] owner_q, owner_d, last_q, last_d, winner;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d, win_valid;
  logic [NREQ-1:0]  req, own_mask;
  logic             owner_req, others_req;

  assign req = ~breq_;

  always_comb begin
    own_mask          = '0;
    own_mask[owner_q] = 1'b1;
  end

  assign owner_req  = req[owner_q];
  assign others_req = |(req & ~own_mask);

  rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req_i    (req),
    .last_i   (last_q),
    .winner_o (winner),
    .valid_o  (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      bgrt_q  <= {NREQ{DISABLE_}};
      prmt_q  <= {NREQ{DISABLE_}};
      owner_q <= '0;
      last_q  <= IDX_W'(NREQ - 1);
      busy_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bgrt_q  <= bgrt_d;
      prmt_q  <= prmt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:  if (win_valid) state_d = ARB_GRANT;
      ARB_GRANT: if (!owner_req) state_d = ARB_TURN;
      ARB_TURN:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    bgrt_d  = {NREQ{DISABLE_}};
    prmt_d  = {NREQ{DISABLE_}};
    owner_d = owner_q;
    last_d  = last_q;
    busy_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          bgrt_d[winner] = ENABLE_;
          owner_d        = winner;
          last_d         = winner;
          busy_d         = 1'b1;
          cnt_d          = '0;
        end
      end
      ARB_GRANT: begin
        if (owner_req) begin
          bgrt_d = bgrt_q;
          busy_d = 1'b1;
          if (cnt_q < CNT_W'(MAX_HOLD)) cnt_d = cnt_q + CNT_W'(1);
          // Advisory only: the owner keeps the bus until it drops its request.
          if (cnt_q >= CNT_W'(MAX_HOLD - 1) && others_req) prmt_d[owner_q] = ENABLE_;
        end
      end
      default: ;
    endcase
  end

  assign bgrt_     = bgrt_q;
  assign prmt_     = prmt_q;
  assign owner     = owner_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and random checks of bus_arbiter against a grant-sequence model.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int NREQ     = 4;
  localparam int IDX_W    = 2;
  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [NREQ-1:0]  breq_ = '1;
  logic [NREQ-1:0]  bgrt_, prmt_;
  logic [IDX_W-1:0] owner;
  logic             busy;
  arb_state_e       state_dbg;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: owner (-1 = bus free), turnaround flag, grant-cycle number
  int m_owner, m_last, m_disp, m_n;
  bit m_turn, m_prmt;
  logic prev_busy;
  int obs_grants[$];

  bus_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .breq_     (breq_),
    .bgrt_     (bgrt_),
    .prmt_     (prmt_),
    .owner     (owner),
    .busy      (busy),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_last  = NREQ - 1;
    m_disp  = 0;
    m_n     = 0;
    m_turn  = 1'b0;
    m_prmt  = 1'b0;
  endfunction

  function automatic void model_step(input logic [NREQ-1:0] r);
    logic [NREQ-1:0] others;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1;
        m_turn  = 1'b1;
        m_prmt  = 1'b0;
      end else begin
        others        = r;
        others[m_owner] = 1'b0;
        m_prmt        = (m_n >= MAX_HOLD) && (others != '0);
        m_n++;
      end
    end else if (m_turn) begin
      m_turn = 1'b0;
    end else if (r != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        int w;
        w = (m_last + k) % NREQ;
        if (m_owner < 0 && r[w]) m_owner = w;
      end
      m_last = m_owner;
      m_disp = m_owner;
      m_n    = 1;
      m_prmt = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    logic [NREQ-1:0] e_g, e_p;
    arb_state_e e_s;
    e_g = '1;
    e_p = '1;
    if (m_owner >= 0) e_g[m_owner] = 1'b0;
    if (m_prmt) e_p[m_owner] = 1'b0;
    e_s = (m_owner >= 0) ? ARB_GRANT : (m_turn ? ARB_TURN : ARB_IDLE);
    chk({tag, ".bgrt_"}, 32'(bgrt_), 32'(e_g));
    chk({tag, ".prmt_"}, 32'(prmt_), 32'(e_p));
    chk({tag, ".owner"}, 32'(owner), 32'(m_disp));
    chk({tag, ".busy"},  32'(busy),  32'(m_owner >= 0));
    chk({tag, ".state"}, 32'(state_dbg), 32'(e_s));
    chk({tag, ".onehot"}, 32'($countones(~bgrt_) <= 1), 32'd1);
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_step(~breq_);
    #1;
    check_all(tag);
    if (busy && !prev_busy) obs_grants.push_back(int'(owner));
    prev_busy = busy;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    breq_ = '1;
    #2;
    model_reset();
    prev_busy = 1'b0;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int rr_exp[5];
    int gap;
    logic [NREQ-1:0] b;
    rr_exp = '{0, 1, 2, 3, 0};

    // single request
    do_reset();
    breq_ = 4'b1011;
    tick("single.grant");
    chk("single.bgrt_", 32'(bgrt_), 32'h0000_000B);
    chk("single.owner", 32'(owner), 32'd2);
    repeat (3) tick("single.hold");
    breq_ = 4'b1111;
    tick("single.release");
    chk("single.turn", 32'(state_dbg), 32'(ARB_TURN));
    tick("single.idle");

    // round-robin with all masters requesting
    do_reset();
    obs_grants.delete();
    for (int t = 0; t < 30; t++) begin
      b = '0;
      if (m_owner >= 0 && m_n >= 3) b[m_owner] = 1'b1;
      breq_ = b;
      tick("rr");
    end
    chk("rr.count_ok", 32'(obs_grants.size() >= 5), 32'd1);
    for (int i = 0; i < 5; i++)
      if (i < obs_grants.size()) chk($sformatf("rr.order%0d", i), 32'(obs_grants[i]), 32'(rr_exp[i]));

    // turnaround: release by 1 while 3 is waiting
    do_reset();
    breq_ = 4'b1101;
    repeat (3) tick("turn.own1");
    breq_ = 4'b0111;
    gap = 0;
    for (int t = 0; t < 10; t++) begin
      tick("turn.wait");
      if (bgrt_[3] == 1'b0) break;
      if (bgrt_ == 4'b1111) gap++;
    end
    chk("turn.gap", 32'(gap), 32'd2);
    chk("turn.bgrt_", 32'(bgrt_), 32'h0000_0007);

    // preempt after the hold time
    do_reset();
    breq_ = 4'b1110;
    tick("prmt.grant");
    breq_ = 4'b1010;
    repeat (15) tick("prmt.hold");
    chk("prmt.before", 32'(prmt_), 32'h0000_000F);
    tick("prmt.edge16");
    chk("prmt.raised", 32'(prmt_), 32'h0000_000E);
    repeat (4) tick("prmt.kept");
    chk("prmt.still_owned", 32'(bgrt_), 32'h0000_000E);
    breq_ = 4'b1011;
    tick("prmt.release");
    chk("prmt.cleared", 32'(prmt_), 32'h0000_000F);
    repeat (3) tick("prmt.next");

    // async reset in the middle of a grant
    do_reset();
    breq_ = 4'b1101;
    repeat (2) tick("areset.own1");
    #2;
    reset = 1'b1;
    #1;
    chk("areset.bgrt_", 32'(bgrt_), 32'h0000_000F);
    chk("areset.busy", 32'(busy), 32'd0);
    model_reset();
    prev_busy = 1'b0;
    breq_ = 4'b0000;
    @(negedge clk);
    reset = 1'b0;
    tick("areset.regrant");
    chk("areset.owner0", 32'(owner), 32'd0);

    // random traffic
    do_reset();
    for (int t = 0; t < 10000; t++) begin
      b = breq_;
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
      breq_ = b;
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
